// File: rtl/unidade_busca.sv
// unidade_busca: instruction fetch unit, the writer side of fila_de_instrucoes.
// It reads 16-bit instructions from a synchronous instruction memory at Pc and
// pushes them into the queue under Full back-pressure. It stops at a HALT opcode.
// Optional feature: define UNIDADE_BUSCA_PREFETCH_EN to issue the next read in
// the same cycle as a push (1 instruction/cycle instead of 1 per 2 cycles).

module unidade_busca #(
    parameter int unsigned           ADDR_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR  = '0,
    parameter logic [2:0]            HALT_OPCODE = 3'b111
) (
    input  logic                  Clock,
    input  logic                  Reset,
    output logic                  Mem_Rd,
    output logic [ADDR_WIDTH-1:0] Mem_Addr,
    input  logic [15:0]           Mem_Data,
    input  logic                  Full,
    output logic                  Push,
    output logic [15:0]           Instrucao_Buscada,
    output logic [ADDR_WIDTH-1:0] Pc,
    output logic                  Halted
);

    typedef enum logic [1:0] {
        StFetch,
        StCapture,
        StStall,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [15:0]             hold_q, hold_d;

    logic                    is_halt;
    logic [ADDR_WIDTH-1:0]   pc_inc;

    // Memory data is only meaningful in CAPTURE; the decode is qualified there.
    assign is_halt = (Mem_Data[15:13] == HALT_OPCODE);
    // Natural wrap modulo 2^ADDR_WIDTH.
    assign pc_inc  = pc_q + ADDR_WIDTH'(1);

    assign Pc = pc_q;

    // State, program counter and stalled-instruction register; synchronous reset.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= StFetch;
            pc_q    <= START_ADDR;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state and outputs; Push is combinational on Full so it can never fire while full.
    always_comb begin
        state_d           = state_q;
        pc_d              = pc_q;
        hold_d            = hold_q;
        Mem_Rd            = 1'b0;
        Mem_Addr          = pc_q;
        Push              = 1'b0;
        Instrucao_Buscada = '0;
        Halted            = 1'b0;

        unique case (state_q)
            StFetch: begin
                Mem_Rd  = 1'b1;
                state_d = StCapture;
            end

            StCapture: begin
                if (is_halt) begin
                    // HALT is consumed here and never reaches the queue.
                    state_d = StDone;
                end else if (!Full) begin
                    Push              = 1'b1;
                    Instrucao_Buscada = Mem_Data;
                    pc_d              = pc_inc;
`ifdef UNIDADE_BUSCA_PREFETCH_EN
                    // Overlap the next read with this push to remove the FETCH bubble.
                    Mem_Rd   = 1'b1;
                    Mem_Addr = pc_inc;
                    state_d  = StCapture;
`else
                    state_d  = StFetch;
`endif
                end else begin
                    // Memory data is only valid this cycle, so park it until the queue drains.
                    hold_d  = Mem_Data;
                    state_d = StStall;
                end
            end

            StStall: begin
                Instrucao_Buscada = hold_q;
                Push              = !Full;
                if (!Full) begin
                    pc_d    = pc_inc;
                    state_d = StFetch;
                end
            end

            StDone: begin
                Halted = 1'b1;
            end

            default: begin
                state_d = StFetch;
            end
        endcase
    end

endmodule
